// File: rtl/pulse_width_decoder_pkg.sv
// ============================================================================
// Module : pulse_pkg
// Brief  : Shared FSM encoding and stretch defaults for stretcher/decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEASURE  = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;

    localparam int STRETCH_W   = 5;
    localparam int STRETCH_TOL = 1;

    // Lower acceptance bound never drops below one cycle.
    function automatic int clamp_lo(input int w, input int tol);
        return (w > tol) ? (w - tol) : 1;
    endfunction

    function automatic int clamp_hi(input int w, input int tol, input int max_w);
        return ((w + tol) > (max_w - 1)) ? (max_w - 1) : (w + tol);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_width_decoder_if.sv
// ============================================================================
// Module : pulse_width_decoder_if
// Brief  : Stretched-pulse input and decode result signals.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_width_decoder_if #(
    parameter int CNT_W = 4
);
    logic             in_level;
    logic             pulse_out;
    logic [CNT_W-1:0] width_out;
    logic             err_short;
    logic             err_long;
    logic             busy;

    modport master (
        output in_level,
        input  pulse_out, width_out, err_short, err_long, busy
    );

    modport slave (
        input  in_level,
        output pulse_out, width_out, err_short, err_long, busy
    );
endinterface

`default_nettype wire

// File: rtl/pulse_width_decoder_sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : 1-bit two-flop synchronizer, async active-high reset to 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule

`default_nettype wire

// File: rtl/pulse_width_decoder.sv
// ============================================================================
// Module : pulse_width_decoder
// Brief  : Measures stretched-pulse high time and accepts/rejects it.
//          Define PULSE_DECODER_SYNC_EN to add a 2-flop input synchronizer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_width_decoder
    import pulse_pkg::*;
#(
    parameter int EXPECT_W = STRETCH_W,
    parameter int TOL      = STRETCH_TOL,
    parameter int CNT_W    = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    pulse_width_decoder_if.slave   bus
);
    localparam int MAX_W_INT = (2 ** CNT_W) - 1;
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_W_INT);
    localparam logic [CNT_W-1:0] LO    = CNT_W'(clamp_lo(EXPECT_W, TOL));
    localparam logic [CNT_W-1:0] HI    = CNT_W'(clamp_hi(EXPECT_W, TOL, MAX_W_INT));

    if ((EXPECT_W + TOL) >= MAX_W_INT || EXPECT_W < 1) begin : g_bad_params
        $error("pulse_width_decoder: illegal EXPECT_W/TOL for CNT_W");
    end

    if ($bits(bus.width_out) != CNT_W) begin : g_bad_if_width
        $error("pulse_width_decoder: interface CNT_W does not match");
    end

    logic w_level;

`ifdef PULSE_DECODER_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.in_level),
        .q   (w_level)
    );
`else
    assign w_level = bus.in_level;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_width;
    logic             r_pulse;
    logic             r_err_short;
    logic             r_err_long;
    logic             r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_LOW;
            r_cnt       <= '0;
            r_width     <= '0;
            r_pulse     <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pulse     <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_level) begin
                        r_state <= MEASURE;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_level) begin
                        if (r_cnt < MAX_W) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end else begin
                            // Saturated: flag once, then ignore the rest of this pulse.
                            r_err_long <= 1'b1;
                            r_width    <= MAX_W;
                            r_busy     <= 1'b0;
                            r_state    <= WAIT_LOW;
                        end
                    end else begin
                        r_width     <= r_cnt;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                        r_pulse     <= (r_cnt >= LO) && (r_cnt <= HI);
                        r_err_short <= (r_cnt < LO);
                        r_err_long  <= (r_cnt > HI);
                    end
                end
                WAIT_LOW: begin
                    if (!w_level) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= WAIT_LOW;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse_out = r_pulse;
    assign bus.width_out = r_width;
    assign bus.err_short = r_err_short;
    assign bus.err_long  = r_err_long;
    assign bus.busy      = r_busy;
endmodule

`default_nettype wire
